// File: rtl/music_sequencer_ctrl.sv
// Control FSM for the note sequencer: turns record/play/clear key presses into
// registered load, playback-address, draw and frame-clear strobes for the datapath.
module music_sequencer_ctrl #(
    parameter int unsigned NOTE_TICKS  = 25000000,
    parameter int unsigned CLEAR_TICKS = 19200,
    parameter int unsigned MAX_NOTES   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_key_record,
    input  logic       i_key_play,
    input  logic       i_key_clear,
    output logic       o_ld_note,
    output logic       o_ld_play,
    output logic [3:0] o_note_counter,
    output logic       o_display_note,
    output logic       o_clear,
    output logic       o_busy,
    output logic [4:0] o_notes_stored
);

    localparam int unsigned MaxTicks = (NOTE_TICKS > CLEAR_TICKS) ? NOTE_TICKS : CLEAR_TICKS;
    localparam int unsigned TickW    = $clog2(MaxTicks + 1);

    localparam logic [TickW-1:0] NoteLast  = TickW'(NOTE_TICKS - 1);
    localparam logic [TickW-1:0] ClearLast = TickW'(CLEAR_TICKS - 1);
    localparam logic [TickW-1:0] DrawTick  = TickW'(2);
    localparam logic [4:0]       NotesMax  = 5'(MAX_NOTES);

    typedef enum logic [1:0] {StIdle, StPlay, StClear} state_e;

    state_e             r_state, w_state_d;
    logic [TickW-1:0]   r_tick, w_tick_d;
    logic [4:0]         r_slot, w_slot_d;
    logic [4:0]         r_stored, w_stored_d;
    logic               r_prev_record, r_prev_play, r_prev_clear;
    logic               w_rec_ev, w_play_ev, w_clr_ev;
    logic               w_ld_note_d, w_ld_play_d, w_display_d, w_clear_d, w_busy_d;
    logic [3:0]         w_note_counter_d;

    assign w_rec_ev  = i_key_record & ~r_prev_record;
    assign w_play_ev = i_key_play & ~r_prev_play;
    assign w_clr_ev  = i_key_clear & ~r_prev_clear;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= StIdle;
            r_tick         <= '0;
            r_slot         <= '0;
            r_stored       <= '0;
            r_prev_record  <= 1'b0;
            r_prev_play    <= 1'b0;
            r_prev_clear   <= 1'b0;
            o_ld_note      <= 1'b0;
            o_ld_play      <= 1'b0;
            o_note_counter <= '0;
            o_display_note <= 1'b0;
            o_clear        <= 1'b0;
            o_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            r_tick         <= w_tick_d;
            r_slot         <= w_slot_d;
            r_stored       <= w_stored_d;
            r_prev_record  <= i_key_record;
            r_prev_play    <= i_key_play;
            r_prev_clear   <= i_key_clear;
            o_ld_note      <= w_ld_note_d;
            o_ld_play      <= w_ld_play_d;
            o_note_counter <= w_note_counter_d;
            o_display_note <= w_display_d;
            o_clear        <= w_clear_d;
            o_busy         <= w_busy_d;
        end
    end

    assign o_notes_stored = r_stored;

    always_comb begin
        w_state_d  = r_state;
        w_tick_d   = r_tick;
        w_slot_d   = r_slot;
        w_stored_d = r_stored;
        unique case (r_state)
            StIdle: begin
                if (w_clr_ev) begin
                    w_state_d  = StClear;
                    w_tick_d   = '0;
                    w_stored_d = '0;
                end else if (w_play_ev && (r_stored != 5'd0)) begin
                    // Stored notes sit at addresses 1..N, so playback starts at 1.
                    w_state_d = StPlay;
                    w_slot_d  = 5'd1;
                    w_tick_d  = '0;
                end else if (w_rec_ev && (r_stored != NotesMax)) begin
                    w_stored_d = r_stored + 5'd1;
                end
            end
            StPlay: begin
                if (w_clr_ev) begin
                    w_state_d  = StClear;
                    w_tick_d   = '0;
                    w_slot_d   = '0;
                    w_stored_d = '0;
                end else if (w_play_ev) begin
                    w_state_d = StIdle;
                    w_tick_d  = '0;
                    w_slot_d  = '0;
                end else if (r_tick == NoteLast) begin
                    w_tick_d = '0;
                    if (r_slot == r_stored) begin
                        w_state_d = StIdle;
                        w_slot_d  = '0;
                    end else begin
                        w_slot_d = r_slot + 5'd1;
                    end
                end else begin
                    w_tick_d = r_tick + TickW'(1);
                end
            end
            StClear: begin
                if (r_tick == ClearLast) begin
                    w_state_d = StIdle;
                    w_tick_d  = '0;
                end else begin
                    w_tick_d = r_tick + TickW'(1);
                end
            end
            default: begin
                w_state_d = StIdle;
                w_tick_d  = '0;
                w_slot_d  = '0;
            end
        endcase
    end

    always_comb begin
        // A record event is honoured only if nothing of higher priority moved us out of idle.
        w_ld_note_d      = (r_state == StIdle) && (w_state_d == StIdle) && w_rec_ev;
        w_ld_play_d      = (w_state_d == StPlay);
        w_note_counter_d = w_ld_play_d ? w_slot_d[3:0] : 4'd0;
        w_display_d      = w_ld_play_d && (w_tick_d == DrawTick);
        w_clear_d        = (w_state_d == StClear);
        w_busy_d         = (w_state_d != StIdle);
    end

endmodule

// File: tb/tb_music_sequencer_ctrl.sv
// Directed self-checking bench for music_sequencer_ctrl with short tick parameters.
module tb_music_sequencer_ctrl;

    localparam int unsigned NT = 8;
    localparam int unsigned CT = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic       key_record, key_play, key_clear;
    logic       ld_note, ld_play, display_note, clear, busy;
    logic [3:0] note_counter;
    logic [4:0] notes_stored;

    int n_checks = 0;
    int n_errors = 0;

    music_sequencer_ctrl #(
        .NOTE_TICKS (NT),
        .CLEAR_TICKS(CT),
        .MAX_NOTES  (16)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .i_key_record  (key_record),
        .i_key_play    (key_play),
        .i_key_clear   (key_clear),
        .o_ld_note     (ld_note),
        .o_ld_play     (ld_play),
        .o_note_counter(note_counter),
        .o_display_note(display_note),
        .o_clear       (clear),
        .o_busy        (busy),
        .o_notes_stored(notes_stored)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Press record for hold cycles; returns ld_note pulses seen and ld_note in the first cycle.
    task automatic press_record(input int hold, output int pulses, output int first);
        pulses = 0;
        key_record = 1'b1;
        for (int c = 0; c < hold; c++) begin
            tick();
            if (c == 0) first = int'(ld_note);
            pulses += int'(ld_note);
        end
        key_record = 1'b0;
        tick();
        pulses += int'(ld_note);
    endtask

    task automatic press_play();
        key_play = 1'b1;
        tick();
        key_play = 1'b0;
    endtask

    int pulses, first, total, cnt_clear, cnt_note, cnt_play, cnt_disp;

    initial begin
        reset = 1'b0;
        key_record = 1'b0;
        key_play = 1'b0;
        key_clear = 1'b0;
        tick();
        tick();
        check("rst_ld_note", ld_note, 0);
        check("rst_ld_play", ld_play, 0);
        check("rst_note_counter", note_counter, 0);
        check("rst_display", display_note, 0);
        check("rst_clear", clear, 0);
        check("rst_busy", busy, 0);
        check("rst_stored", notes_stored, 0);
        reset = 1'b1;
        tick();

        // Play with nothing stored is ignored.
        press_play();
        check("empty_play_ld_play", ld_play, 0);
        check("empty_play_busy", busy, 0);
        tick();
        check("empty_play_busy2", busy, 0);

        // Three held record presses.
        total = 0;
        for (int k = 0; k < 3; k++) begin
            press_record(10, pulses, first);
            check("rec_first_cycle", first, 1);
            total += pulses;
        end
        check("rec3_pulses", total, 3);
        check("rec3_stored", notes_stored, 3);

        // Playback of three notes: 24 cycles, draw at slot cycle 2.
        press_play();
        for (int c = 0; c < 3 * NT; c++) begin
            check("play3_ld_play", ld_play, 1);
            check("play3_note_counter", note_counter, c / NT + 1);
            check("play3_display", display_note, ((c % NT) == 2) ? 1 : 0);
            check("play3_ld_note", ld_note, 0);
            tick();
        end
        check("play3_end_ld_play", ld_play, 0);
        check("play3_end_note_counter", note_counter, 0);
        check("play3_end_busy", busy, 0);

        // Abort by second play press during slot 2.
        press_play();
        for (int c = 0; c < NT + 2; c++) tick();
        check("abort_pre_counter", note_counter, 2);
        press_play();
        check("abort_ld_play", ld_play, 0);
        check("abort_note_counter", note_counter, 0);
        check("abort_display", display_note, 0);
        check("abort_busy", busy, 0);
        tick();

        // Clear mid-play; record presses during clear are ignored, held keys don't fire on exit.
        press_play();
        for (int c = 0; c < 4; c++) tick();
        key_clear = 1'b1;
        tick();
        check("clr_ld_play", ld_play, 0);
        check("clr_stored", notes_stored, 0);
        cnt_clear = 0;
        cnt_note = 0;
        for (int c = 0; c < 10; c++) begin
            if (c == 0) check("clr_first", clear, 1);
            if (c == CT) check("clr_after", clear, 0);
            cnt_clear += int'(clear);
            cnt_note += int'(ld_note);
            key_record = (c == 1 || c >= 3) ? 1'b1 : 1'b0;
            tick();
        end
        check("clr_cycles", cnt_clear, CT);
        check("clr_ld_note", cnt_note, 0);
        check("clr_held_busy", busy, 0);
        check("clr_held_stored", notes_stored, 0);
        key_record = 1'b0;
        key_clear = 1'b0;
        tick();

        // Seventeen records saturate at 16, each still pulses ld_note.
        total = 0;
        for (int k = 0; k < 17; k++) begin
            press_record(2, pulses, first);
            total += pulses;
        end
        check("rec17_pulses", total, 17);
        check("rec17_stored", notes_stored, 16);

        press_play();
        cnt_play = 0;
        cnt_disp = 0;
        for (int c = 0; c < 16 * NT; c++) begin
            if ((c % NT) == 0) check("play16_note_counter", note_counter, (c / NT + 1) % 16);
            cnt_play += int'(ld_play);
            cnt_disp += int'(display_note);
            tick();
        end
        check("play16_ld_play_cycles", cnt_play, 16 * NT);
        check("play16_display_count", cnt_disp, 16);
        check("play16_end_ld_play", ld_play, 0);
        check("play16_end_busy", busy, 0);

        // Coincident record+play+clear edges in idle: clear wins.
        key_record = 1'b1;
        key_play = 1'b1;
        key_clear = 1'b1;
        tick();
        check("prio_clear", clear, 1);
        check("prio_ld_note", ld_note, 0);
        check("prio_ld_play", ld_play, 0);
        check("prio_stored", notes_stored, 0);
        key_record = 1'b0;
        key_play = 1'b0;
        key_clear = 1'b0;
        for (int c = 0; c < CT + 1; c++) tick();
        check("prio_done_busy", busy, 0);

        // Reset overrides playback.
        press_record(1, pulses, first);
        press_play();
        tick();
        check("rst_mid_pre_ld_play", ld_play, 1);
        reset = 1'b0;
        tick();
        check("rst_mid_ld_play", ld_play, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_stored", notes_stored, 0);
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/music_sequencer_ctrl.md
Name: music_sequencer_ctrl

Overview:
- Control stage directly upstream of the note datapath. Turns user key inputs into the datapath's control strobes.
- Record: `ld_note` pulses store one note per key press.
- Play: walks `note_counter` through the stored notes at a fixed tempo, with `ld_play` held high and a `display_note` strobe per note.
- Clear: holds `clear` long enough to wipe the VGA frame and forgets the stored notes.

Parameters:
- NOTE_TICKS, 25000000, cycles per played note slot (0.5 s at 50 MHz); must be >= 4.
- CLEAR_TICKS, 19200, cycles `clear` is held high (160x120 frame).
- MAX_NOTES, 16, memory depth; `note_counter` width is 4 bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- key_record  input  1  record key, synchronous level, active-high.
- key_play  input  1  play/stop key, synchronous level, active-high.
- key_clear  input  1  clear key, synchronous level, active-high.
- ld_note  output  1  one-cycle write strobe to the datapath.
- ld_play  output  1  high for the whole playback.
- note_counter  output  4  memory address to play.
- display_note  output  1  one-cycle draw strobe per played note.
- clear  output  1  VGA clear request.
- busy  output  1  high in any state other than IDLE.
- notes_stored  output  5  count of recorded notes, 0..16.

Behaviour:
- Reset (reset==0 at posedge clk):
  - All outputs 0; state IDLE; all counters 0.
  - Previous-key registers are set to 0.
  - Reset overrides everything, including mid-play and mid-clear.
- Edge detection:
  - Each key is registered every cycle.
  - An event is key==1 while prev==0, detected in cycle t.
  - A held key produces exactly one event.
- States: IDLE, PLAY, CLEAR.
- Event priority in IDLE when events coincide: clear > play > record.
- Record (IDLE only):
  - A record event in cycle t gives `ld_note`=1 in cycle t+1 only.
  - `notes_stored` increments at the same edge and saturates at 16.
  - `ld_note` still pulses when `notes_stored`==16 (the datapath overwrites on wrap).
  - Record events outside IDLE are ignored.
- Play start:
  - A play event in IDLE with `notes_stored`==0 is ignored; state stays IDLE.
  - Otherwise go to PLAY with slot index i=1 and slot cycle s=0.
  - The datapath pre-increments its write address, so stored notes live at addresses 1..N.
- PLAY:
  - `ld_play`=1 throughout.
  - `note_counter` = i mod 16, valid from s=0 of each slot.
  - s counts 0..NOTE_TICKS-1.
  - `display_note`=1 only at s=2 (allows 2-cycle memory read latency).
  - At s=NOTE_TICKS-1: if i==`notes_stored`, go to IDLE; otherwise i+1 and s=0.
  - Each slot lasts exactly NOTE_TICKS cycles.
  - A play event in PLAY aborts: next cycle IDLE, with `ld_play`, `note_counter` and `display_note` = 0.
  - A clear event in PLAY aborts play and enters CLEAR.
- Leaving PLAY (normal end or abort): `ld_play`=0 and `note_counter`=0 in the first IDLE cycle.
- CLEAR:
  - Entered on a clear event in cycle t.
  - `clear`=1 for cycles t+1..t+CLEAR_TICKS exactly, then IDLE.
  - `notes_stored` is set to 0 on entry.
  - All key events during CLEAR are ignored. Edge registers keep tracking, so a key held through CLEAR does not fire on exit.
- Output and width rules:
  - All outputs are registered.
  - `ld_note`, `ld_play` and `clear` are never high in the same cycle.
  - Tick counters are sized to ceil(log2(max(NOTE_TICKS, CLEAR_TICKS)+1)) bits.

Test Plan (NOTE_TICKS=8, CLEAR_TICKS=5):
- Reset with reset=0 for 2 cycles -> all outputs 0, `busy`=0, `notes_stored`=0.
- Hold key_record high 10 cycles, repeat 3 times -> exactly 3 single-cycle `ld_note` pulses, each one cycle after the rising edge; `notes_stored`=3.
- After 3 records, press play -> `ld_play` high 24 cycles; `note_counter` = 1,1,…(8 cycles), then 2×8, then 3×8; `display_note` at slot cycles 2, 10, 18; then IDLE with `note_counter`=0.
- 17 record presses -> 17 `ld_note` pulses; `notes_stored` saturates at 16. Play -> `note_counter` sequence 1..15, 0, 16 slots total.
- Play during slot 2, then press play again -> `ld_play` drops next cycle. Separately, press key_clear mid-play -> `clear` high exactly 5 cycles, `notes_stored`=0, record presses during the clear produce no `ld_note`.
- In IDLE with `notes_stored`=0, press play -> no `ld_play`, `busy` stays 0. Simultaneous record+play+clear edges -> only CLEAR taken.
